z80_reti: RTL and testbench

Z80_RETI -- requirements
Module: z80_reti

---
 rtl/z80_reti.sv | 86 ++++++++
 tb/tb_z80_reti.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_reti.sv
// Z80 RETI snooper: watches M1 opcode fetches on the CPU bus and pulses
// O_RETI for one enabled cycle when the ED 4D sequence completes.
module z80_reti (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_CLKEN,
  input  logic       I_M1_n,
  input  logic       I_MREQ_n,
  input  logic       I_IORQ_n,
  input  logic       I_RD_n,
  input  logic [7:0] I_D,
  output logic       O_SPM1,
  output logic       O_RETI,
  output logic       O_ED
);

  typedef enum logic [1:0] {
    IDLE,
    PFX,
    CBS,
    EDS
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] opcode;
  logic       fetch;
  logic       fetch_r;
  logic       fetch_end;
  logic       int_ack;
  logic       reti_nx;
  logic       is_ed;
  logic       is_cb;
  logic       is_pfx;

  assign fetch     = ~I_M1_n & ~I_MREQ_n & ~I_RD_n;
  assign int_ack   = ~I_M1_n & ~I_IORQ_n;
  assign fetch_end = fetch_r & ~fetch;
  assign O_SPM1    = ~I_RESET & int_ack;

  assign is_ed  = (opcode == 8'hED);
  assign is_cb  = (opcode == 8'hCB);
  assign is_pfx = (opcode == 8'hDD) | (opcode == 8'hFD);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state   <= IDLE;
      fetch_r <= 1'b0;
      opcode  <= 8'h00;
      O_RETI  <= 1'b0;
    end else if (I_CLKEN) begin
      state   <= state_nx;
      fetch_r <= fetch;
      O_RETI  <= reti_nx;
      if (fetch)
        opcode <= I_D;
    end
  end

  // Interrupt acknowledge wins over a fetch ending on the same edge.
  always_comb begin
    state_nx = state;
    if (int_ack) begin
      state_nx = IDLE;
    end else if (fetch_end) begin
      case (state)
        IDLE, PFX: begin
          unique case (1'b1)
            is_ed:   state_nx = EDS;
            is_pfx:  state_nx = PFX;
            is_cb:   state_nx = (state == IDLE) ? CBS : IDLE;
            default: state_nx = IDLE;
          endcase
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    O_ED    = (state == EDS);
    reti_nx = ~int_ack & fetch_end &
              (state == EDS) & (opcode == 8'h4D);
  end

endmodule

// File: tb/tb_z80_reti.sv
// Bench for z80_reti: directed scenarios plus randomized bus traffic
// checked against an instruction-level reference model.
module tb_z80_reti;

  logic       clk = 1'b0;
  logic       rst;
  logic       clken;
  logic       m1_n;
  logic       mreq_n;
  logic       iorq_n;
  logic       rd_n;
  logic [7:0] d;
  logic       spm1;
  logic       reti;
  logic       ed;

  int n_pass  = 0;
  int n_total = 0;

  // Model: bytes of the instruction currently being fetched.
  logic [7:0] ins[$];
  bit         m_prev;
  logic [7:0] m_last;
  bit         m_reti;

  always #5 clk = ~clk;

  z80_reti dut (
    .I_CLK    (clk),
    .I_RESET  (rst),
    .I_CLKEN  (clken),
    .I_M1_n   (m1_n),
    .I_MREQ_n (mreq_n),
    .I_IORQ_n (iorq_n),
    .I_RD_n   (rd_n),
    .I_D      (d),
    .O_SPM1   (spm1),
    .O_RETI   (reti),
    .O_ED     (ed)
  );

  task automatic set_bus(input logic m1, input logic mreq,
                         input logic iorq, input logic rd,
                         input logic [7:0] dv);
    m1_n   = m1;
    mreq_n = mreq;
    iorq_n = iorq;
    rd_n   = rd;
    d      = dv;
  endtask

  task automatic idle_bus();
    set_bus(1, 1, 1, 1, 8'hFF);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [7:0] b, input int n);
    set_bus(0, 0, 1, 0, b);
    repeat (n) tick();
    idle_bus();
    tick();
  endtask

  task automatic m_consume(input logic [7:0] b);
    bit         have;
    logic [7:0] last;
    have = ins.size() > 0;
    last = have ? ins[$] : 8'h00;
    if (have && (last == 8'hCB || last == 8'hED)) begin
      m_reti = (last == 8'hED) && (b == 8'h4D);
      ins.delete();
    end else if (b == 8'hDD || b == 8'hFD || b == 8'hED) begin
      ins.push_back(b);
    end else if (b == 8'hCB) begin
      if (have) ins.delete();
      else ins.push_back(b);
    end else begin
      ins.delete();
    end
  endtask

  task automatic model_step();
    bit f;
    bit ack;
    if (rst) begin
      ins.delete();
      m_prev = 0;
      m_last = 8'h00;
      m_reti = 0;
    end else if (clken) begin
      f   = !m1_n && !mreq_n && !rd_n;
      ack = !m1_n && !iorq_n;
      m_reti = 0;
      if (ack) ins.delete();
      else if (m_prev && !f) m_consume(m_last);
      if (f) m_last = d;
      m_prev = f;
    end
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 7))
      0: return 8'hED;
      1: return 8'h4D;
      2: return 8'h45;
      3: return 8'hDD;
      4: return 8'hFD;
      5: return 8'hCB;
      6: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst   = 1;
    clken = 0;
    set_bus(0, 1, 0, 1, 8'hED);
    #1;
    n_total++;
    if (spm1 !== 1'b0) $display("FAIL reset_spm1: got %b want 0", spm1);
    else n_pass++;
    tick();
    n_total++;
    if ({reti, ed} !== 2'b00)
      $display("FAIL reset_outs: got reti/ed %b want 00", {reti, ed});
    else n_pass++;
    clken = 1;
    idle_bus();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_basic_reti();
    do_fetch(8'hED, 2);
    n_total++;
    if ({reti, ed} !== 2'b01)
      $display("FAIL basic_after_ed: got reti/ed %b want 01", {reti, ed});
    else n_pass++;
    set_bus(0, 0, 1, 0, 8'h4D);
    tick();
    n_total++;
    if (ed !== 1'b1) $display("FAIL basic_ed_hold: got %b want 1", ed);
    else n_pass++;
    tick();
    idle_bus();
    tick();
    n_total++;
    if ({reti, ed} !== 2'b10)
      $display("FAIL basic_pulse: got reti/ed %b want 10", {reti, ed});
    else n_pass++;
    tick();
    n_total++;
    if (reti !== 1'b0) $display("FAIL basic_width: got %b want 0", reti);
    else n_pass++;
  endtask

  task automatic test_non_reti();
    do_fetch(8'hED, 2);
    do_fetch(8'h45, 2);
    n_total++;
    if ({reti, ed} !== 2'b00)
      $display("FAIL retn: got reti/ed %b want 00", {reti, ed});
    else n_pass++;
    do_fetch(8'hED, 1);
    do_fetch(8'hED, 1);
    n_total++;
    if (ed !== 1'b0) $display("FAIL ed_ed_state: got %b want 0", ed);
    else n_pass++;
    do_fetch(8'h4D, 1);
    n_total++;
    if (reti !== 1'b0) $display("FAIL ed_ed_4d: got %b want 0", reti);
    else n_pass++;
    tick();
  endtask

  task automatic test_prefix();
    do_fetch(8'hDD, 1);
    do_fetch(8'hED, 1);
    do_fetch(8'h4D, 1);
    n_total++;
    if (reti !== 1'b1) $display("FAIL pfx_dd: got %b want 1", reti);
    else n_pass++;
    tick();
    do_fetch(8'hCB, 1);
    do_fetch(8'hED, 1);
    do_fetch(8'h4D, 1);
    n_total++;
    if (reti !== 1'b0) $display("FAIL pfx_cb: got %b want 0", reti);
    else n_pass++;
    tick();
    do_fetch(8'hFD, 1);
    do_fetch(8'hCB, 1);
    set_bus(1, 0, 1, 0, 8'h05);
    tick();
    idle_bus();
    tick();
    set_bus(1, 0, 1, 0, 8'h4D);
    tick();
    idle_bus();
    tick();
    do_fetch(8'hED, 1);
    do_fetch(8'h4D, 1);
    n_total++;
    if (reti !== 1'b1) $display("FAIL pfx_fdcb: got %b want 1", reti);
    else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    int highs;
    highs = 0;
    clken = 1;
    do_fetch(8'hED, 1);
    set_bus(0, 0, 1, 0, 8'h4D);
    for (int i = 0; i < 10; i++) begin
      clken = (i % 2 == 0);
      tick();
      highs += int'(reti);
    end
    idle_bus();
    clken = 1;
    tick();
    n_total++;
    if (reti !== 1'b1 || highs != 0)
      $display("FAIL stall_pulse: got reti %b early %0d want 1 0",
               reti, highs);
    else n_pass++;
    clken = 0;
    tick();
    tick();
    n_total++;
    if (reti !== 1'b1) $display("FAIL stall_hold: got %b want 1", reti);
    else n_pass++;
    clken = 1;
    tick();
    n_total++;
    if (reti !== 1'b0) $display("FAIL stall_end: got %b want 0", reti);
    else n_pass++;
  endtask

  task automatic test_int_ack();
    set_bus(0, 1, 0, 1, 8'hED);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({spm1, ed} !== 2'b10)
        $display("FAIL ack_hold: got spm1/ed %b want 10", {spm1, ed});
      else n_pass++;
    end
    idle_bus();
    tick();
    do_fetch(8'h4D, 1);
    n_total++;
    if (reti !== 1'b0) $display("FAIL ack_no_eds: got %b want 0", reti);
    else n_pass++;
    do_fetch(8'hED, 1);
    set_bus(0, 1, 0, 1, 8'h00);
    tick();
    n_total++;
    if (ed !== 1'b0) $display("FAIL ack_abort: got %b want 0", ed);
    else n_pass++;
    idle_bus();
    tick();
    do_fetch(8'h4D, 1);
    n_total++;
    if (reti !== 1'b0) $display("FAIL ack_abort_4d: got %b want 0", reti);
    else n_pass++;
    set_bus(0, 0, 1, 0, 8'hED);
    tick();
    set_bus(0, 1, 0, 1, 8'hED);
    tick();
    idle_bus();
    tick();
    n_total++;
    if (ed !== 1'b0) $display("FAIL ack_priority: got %b want 0", ed);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    do_fetch(8'hED, 1);
    n_total++;
    if (ed !== 1'b1) $display("FAIL abort_pre: got %b want 1", ed);
    else n_pass++;
    rst = 1;
    tick();
    rst = 0;
    n_total++;
    if (ed !== 1'b0) $display("FAIL abort_ed: got %b want 0", ed);
    else n_pass++;
    do_fetch(8'h4D, 1);
    n_total++;
    if (reti !== 1'b0) $display("FAIL abort_reti: got %b want 0", reti);
    else n_pass++;
  endtask

  task automatic test_random();
    int   kind;
    int   len;
    logic exp_ed;
    logic exp_spm1;
    rst = 1;
    clken = 1;
    idle_bus();
    tick();
    model_step();
    rst = 0;
    for (int op = 0; op < 600; op++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 3);
      if (kind <= 5) set_bus(0, 0, 1, 0, pick_byte());
      else if (kind == 6) set_bus(0, 1, 0, 1, pick_byte());
      else if (kind == 7) set_bus(1, 0, 1, 0, pick_byte());
      else set_bus(1, 1, 1, 1, pick_byte());
      rst = (kind == 9) && ($urandom_range(0, 4) == 0);
      for (int c = 0; c < len; c++) begin
        clken = ($urandom_range(0, 3) != 0);
        tick();
        model_step();
        exp_ed   = (ins.size() > 0) ? (ins[$] == 8'hED) : 1'b0;
        exp_spm1 = !rst && !m1_n && !iorq_n;
        n_total++;
        if (reti !== m_reti)
          $display("FAIL rand_reti t=%0t: got %b want %b",
                   $time, reti, m_reti);
        else n_pass++;
        n_total++;
        if (ed !== exp_ed)
          $display("FAIL rand_ed t=%0t: got %b want %b",
                   $time, ed, exp_ed);
        else n_pass++;
        n_total++;
        if (spm1 !== exp_spm1)
          $display("FAIL rand_spm1 t=%0t: got %b want %b",
                   $time, spm1, exp_spm1);
        else n_pass++;
      end
      rst = 0;
    end
  endtask

  initial begin
    rst   = 1;
    clken = 1;
    idle_bus();
    test_reset();
    test_basic_reti();
    test_non_reti();
    test_prefix();
    test_stall();
    test_int_ack();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
